// File: rtl/ia_pkg.sv
// ia_pkg: image geometry, plane bases, FSM state encoding and range helper shared by the centroid block
package ia_pkg;
  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int PLANE_SIZE = 16384;
  localparam int IMG_WORDS = 49152;
  localparam logic [15:0] R_BASE = 16'd0;
  localparam logic [15:0] G_BASE = 16'd16384;
  localparam logic [15:0] B_BASE = 16'd32768;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_DIVX  = 3'd3,
    S_DIVY  = 3'd4,
    S_DONE  = 3'd5
  } state_t;
  function automatic logic in_rng(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/ia_seq_divider.sv
// ia_seq_divider: restoring divider, 21-bit / 15-bit -> 7-bit quotient, 1 load + 21 iteration cycles
module ia_seq_divider (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [20:0] i_dividend,
  input  logic [14:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [6:0]  o_quot
);
  logic [14:0] rem;
  logic [20:0] dq;
  logic [4:0]  cnt;
  logic [15:0] rem_s;
  logic        ge;
  assign rem_s = {rem, dq[20]};
  assign ge = rem_s >= {1'b0, i_divisor};
  assign o_done = o_busy && cnt == 5'd20;
  assign o_quot = dq[6:0];
  // load on start, then shift one quotient bit into dq per cycle; o_done marks the last iteration
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem <= '0;
      dq <= '0;
      cnt <= '0;
      o_busy <= 1'b0;
    end else if (i_start) begin
      rem <= '0;
      dq <= i_dividend;
      cnt <= '0;
      o_busy <= 1'b1;
    end else if (o_busy) begin
      rem <= 15'(ge ? rem_s - {1'b0, i_divisor} : rem_s);
      dq <= {dq[19:0], ge};
      cnt <= cnt + 5'd1;
      o_busy <= !o_done;
    end
  end
endmodule

// File: rtl/ia_color_centroid.sv
// ia_color_centroid: colour-threshold scan of the 128x128x3 buffer, centroid via shared divider; bbox trackers under IA_CENTROID_BBOX_EN
module ia_color_centroid
  import ia_pkg::*;
#(
  parameter logic [9:0] R_MIN = 10'd600,
  parameter logic [9:0] R_MAX = 10'd1023,
  parameter logic [9:0] G_MIN = 10'd0,
  parameter logic [9:0] G_MAX = 10'd300,
  parameter logic [9:0] B_MIN = 10'd0,
  parameter logic [9:0] B_MAX = 10'd300,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_rd_en,
  output logic [15:0] o_rd_addr,
  input  logic [9:0]  i_rd_data,
  output logic        o_valid,
  output logic        o_found,
  output logic [14:0] o_count,
  output logic [6:0]  o_cx,
  output logic [6:0]  o_cy,
  output logic [6:0]  o_xmin,
  output logic [6:0]  o_xmax,
  output logic [6:0]  o_ymin,
  output logic [6:0]  o_ymax
);
  state_t state, state_nx;
  logic [1:0]  ch, ch_d;
  logic [13:0] p, p_d;
  logic        v_d;
  logic [9:0]  r_h, g_h;
  logic [14:0] count, cnt_nx;
  logic [20:0] sum_x, sum_y;
  logic        found_r, found_c;
  logic [6:0]  cx_r, px, py, div_q;
  logic        accept, last, hit, div_start, div_done, div_busy;
  assign accept = state == S_IDLE && i_start && !o_valid;
  assign last = ch == 2'd2 && p == 14'h3FFF;
  assign px = p_d[6:0];
  assign py = p_d[13:7];
  assign hit = v_d && ch_d == 2'd2 && in_rng(r_h, R_MIN, R_MAX) && in_rng(g_h, G_MIN, G_MAX) && in_rng(i_rd_data, B_MIN, B_MAX);
  assign cnt_nx = count + 15'(hit);
  assign found_c = cnt_nx != 15'd0 && 32'(cnt_nx) >= MIN_PIXELS;
  assign div_start = (state == S_DIVX || state == S_DIVY) && !div_busy;
  assign o_busy = state != S_IDLE;
  assign o_rd_en = state == S_SCAN;
  assign o_rd_addr = (ch == 2'd0 ? R_BASE : ch == 2'd1 ? G_BASE : B_BASE) + {2'b00, p};
  ia_seq_divider u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (div_start),
    .i_dividend (state == S_DIVX ? sum_x : sum_y),
    .i_divisor  (count),
    .o_busy     (div_busy),
    .o_done     (div_done),
    .o_quot     (div_q)
  );
  // state register
  always_ff @(posedge i_clk) begin
    state <= i_rst ? S_IDLE : state_nx;
  end
  // next-state: scan all words, drain the last read, divide only when the object is found
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = accept ? S_SCAN : S_IDLE;
      S_SCAN:  state_nx = last ? S_DRAIN : S_SCAN;
      S_DRAIN: state_nx = found_c ? S_DIVX : S_DONE;
      S_DIVX:  state_nx = div_done ? S_DIVY : S_DIVX;
      S_DIVY:  state_nx = div_done ? S_DONE : S_DIVY;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  // read sequencing, R/G holding, match accumulation and the X quotient capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ch <= '0;
      p <= '0;
      v_d <= 1'b0;
      ch_d <= '0;
      p_d <= '0;
      r_h <= '0;
      g_h <= '0;
      count <= '0;
      sum_x <= '0;
      sum_y <= '0;
      found_r <= 1'b0;
      cx_r <= '0;
    end else begin
      v_d <= o_rd_en;
      ch_d <= ch;
      p_d <= p;
      if (o_rd_en) begin
        ch <= ch == 2'd2 ? 2'd0 : ch + 2'd1;
        p <= ch == 2'd2 ? p + 14'd1 : p;
      end
      if (v_d && ch_d == 2'd0) r_h <= i_rd_data;
      if (v_d && ch_d == 2'd1) g_h <= i_rd_data;
      if (hit) begin
        count <= cnt_nx;
        sum_x <= sum_x + 21'(px);
        sum_y <= sum_y + 21'(py);
      end
      if (accept) begin
        ch <= '0;
        p <= '0;
        count <= '0;
        sum_x <= '0;
        sum_y <= '0;
      end
      if (state == S_DRAIN) found_r <= found_c;
      if (state == S_DIVY && div_start) cx_r <= div_q;
    end
  end
  // result registers, updated together with the o_valid pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_found <= 1'b0;
      o_count <= '0;
      o_cx <= '0;
      o_cy <= '0;
    end else begin
      o_valid <= state == S_DONE;
      if (state == S_DONE) begin
        o_found <= found_r;
        o_count <= count;
        o_cx <= found_r ? cx_r : 7'd0;
        o_cy <= found_r ? div_q : 7'd0;
      end
    end
  end
`ifdef IA_CENTROID_BBOX_EN
  logic [6:0] xmin, xmax, ymin, ymax;
  // bounding-box trackers, preset to an empty box when a scan is accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
    end else if (accept) begin
      xmin <= 7'd127;
      xmax <= 7'd0;
      ymin <= 7'd127;
      ymax <= 7'd0;
    end else if (hit) begin
      xmin <= px < xmin ? px : xmin;
      xmax <= px > xmax ? px : xmax;
      ymin <= py < ymin ? py : ymin;
      ymax <= py > ymax ? py : ymax;
    end
  end
  // bbox outputs, zero when nothing was found
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_xmin <= '0;
      o_xmax <= '0;
      o_ymin <= '0;
      o_ymax <= '0;
    end else if (state == S_DONE) begin
      o_xmin <= found_r ? xmin : 7'd0;
      o_xmax <= found_r ? xmax : 7'd0;
      o_ymin <= found_r ? ymin : 7'd0;
      o_ymax <= found_r ? ymax : 7'd0;
    end
  end
`else
  assign o_xmin = '0;
  assign o_xmax = '0;
  assign o_ymin = '0;
  assign o_ymax = '0;
`endif
endmodule

// File: tb/tb_ia_color_centroid.sv
// tb_ia_color_centroid: six parallel instances over directed images, checks results, latency, address order and reset abort
module tb_ia_color_centroid;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, rst_f = 1'b1;
  logic [5:0] start = '0;
  logic [5:0] rs, busy, rd_en, valid, found;
  logic [15:0] addr [6];
  logic [9:0] rdata [6];
  logic [14:0] cnt [6];
  logic [6:0] cx [6], cy [6], xmin [6], xmax [6], ymin [6], ymax [6];
  int cyc = 0, checks = 0, failures = 0, aerr = 0, nrd = 0, a = 0, af = 0;
  int vn [6] = '{default: 0};
  int vat [6] = '{default: 0};
  int e_lat [6] = '{49198, 49198, 49154, 49198, 49154, 49198};
  int e_fnd [6] = '{1, 1, 0, 1, 0, 1};
  int e_cnt [6] = '{1, 64, 0, 2, 2, 64};
  int e_cx [6] = '{10, 43, 0, 63, 0, 43};
  int e_cy [6] = '{20, 63, 0, 63, 0, 63};
  int e_x0 [6] = '{10, 40, 0, 0, 0, 40};
  int e_x1 [6] = '{10, 47, 0, 127, 0, 47};
  int e_y0 [6] = '{20, 60, 0, 0, 0, 60};
  int e_y1 [6] = '{20, 67, 0, 127, 0, 67};
  assign rs = {rst_f, {5{rst}}};
  function automatic int bb(int v);
`ifdef IA_CENTROID_BBOX_EN
    return v;
`else
    return 0;
`endif
  endfunction
  function automatic logic [9:0] pix(int k, logic [15:0] ad);
    logic [6:0] x = ad[6:0];
    logic [6:0] y = ad[13:7];
    logic [29:0] c = '0;
    if (k == 0 && y == 20)
      c = x == 10 ? {10'd800, 10'd100, 10'd100} : x == 11 ? {10'd599, 10'd100, 10'd100} :
          x == 12 ? {10'd800, 10'd301, 10'd100} : x == 13 ? {10'd800, 10'd100, 10'd301} : '0;
    if ((k == 1 || k == 5) && x >= 40 && x <= 47 && y >= 60 && y <= 67)
      c = x[0] ? {10'd1023, 10'd0, 10'd0} : {10'd600, 10'd300, 10'd300};
    if ((k == 3 || k == 4) && ((x == 0 && y == 0) || (x == 127 && y == 127)))
      c = {10'd800, 10'd0, 10'd0};
    return ad[15:14] == 2'd0 ? c[29:20] : ad[15:14] == 2'd1 ? c[19:10] : c[9:0];
  endfunction
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 6; g++) begin : g_dut
    ia_color_centroid #(.MIN_PIXELS(g == 0 || g == 3 ? 1 : g == 4 ? 3 : 16)) u_dut (
      .i_clk     (clk),
      .i_rst     (rs[g]),
      .i_start   (start[g]),
      .o_busy    (busy[g]),
      .o_rd_en   (rd_en[g]),
      .o_rd_addr (addr[g]),
      .i_rd_data (rdata[g]),
      .o_valid   (valid[g]),
      .o_found   (found[g]),
      .o_count   (cnt[g]),
      .o_cx      (cx[g]),
      .o_cy      (cy[g]),
      .o_xmin    (xmin[g]),
      .o_xmax    (xmax[g]),
      .o_ymin    (ymin[g]),
      .o_ymax    (ymax[g])
    );
    always @(posedge clk) rdata[g] <= pix(g, addr[g]);
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int k = 0; k < 6; k++)
      if (valid[k]) begin
        vn[k]++;
        vat[k] = cyc;
      end
    if (rd_en[0]) begin
      if (int'(addr[0]) != (nrd % 3) * 16384 + nrd / 3) aerr++;
      nrd++;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy[0], 0);
    check("rst_rd_en", rd_en[0], 0);
    check("rst_valid", valid[0], 0);
    check("rst_count", cnt[0], 0);
    check("rst_cx", cx[0], 0);
    rst = 1'b0;
    rst_f = 1'b0;
    @(negedge clk);
    start = '1;
    @(negedge clk);
    a = cyc;
    start = '0;
    while (cyc < a + 500) @(negedge clk);
    start = '1;
    @(negedge clk);
    start = '0;
    while (cyc < a + 1000) @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    check("abort_busy", busy[5], 0);
    check("abort_rd_en", rd_en[5], 0);
    check("abort_valid", valid[5], 0);
    check("abort_count", cnt[5], 0);
    check("abort_found", found[5], 0);
    start[5] = 1'b1;
    @(negedge clk);
    af = cyc;
    start[5] = 1'b0;
    while (cyc < a + 49154) @(negedge clk);
    check("black_valid_now", valid[2], 1);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    check("start_on_valid_ignored", busy[2], 0);
    while (cyc < af + 49260) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("pulses%0d", k), vn[k], 1);
      check($sformatf("latency%0d", k), vat[k] - (k == 5 ? af : a), e_lat[k]);
      check($sformatf("found%0d", k), found[k], e_fnd[k]);
      check($sformatf("count%0d", k), cnt[k], e_cnt[k]);
      check($sformatf("cx%0d", k), cx[k], e_cx[k]);
      check($sformatf("cy%0d", k), cy[k], e_cy[k]);
      check($sformatf("xmin%0d", k), xmin[k], bb(e_x0[k]));
      check($sformatf("xmax%0d", k), xmax[k], bb(e_x1[k]));
      check($sformatf("ymin%0d", k), ymin[k], bb(e_y0[k]));
      check($sformatf("ymax%0d", k), ymax[k], bb(e_y1[k]));
      check($sformatf("idle%0d", k), busy[k], 0);
    end
    check("addr_seq_errors", aerr, 0);
    check("rd_cycles", nrd, 49152);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
